// File: rtl/ibex_microarchtrace_replay.sv
// Replays captured per-cycle pipeline-event records as Ibex fetch and ID/EX handshake waveforms.
// A one-entry hold register feeds a gap counter that schedules each record's apply edge.
module ibex_microarchtrace_replay #(
  parameter int DELTA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_if_type,
  input  logic [1:0]         ev_idex_type,
  input  logic [DELTA_W-1:0] ev_delta,
  input  logic [31:0]        ev_if_pc,
  input  logic [31:0]        ev_if_insn,
  input  logic               ev_if_c,
  input  logic [15:0]        ev_if_c_insn,
  input  logic [31:0]        ev_idex_pc,
  output logic               fetch_ready,
  output logic               fetch_valid,
  output logic [31:0]        fetch_pc,
  output logic [31:0]        fetch_insn,
  output logic               fetch_c,
  output logic [15:0]        fetch_c_insn,
  output logic               idex_executing,
  output logic               idex_done,
  output logic [31:0]        idex_pc,
  output logic               busy,
  output logic               proto_err,
  output logic               underrun
);

  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_SINGLE = 2'd1;
  localparam logic [1:0] EV_START  = 2'd2;
  localparam logic [1:0] EV_END    = 2'd3;

  typedef enum logic {F_IDLE, F_STALL} f_state_t;
  typedef enum logic {X_IDLE, X_MULT}  x_state_t;

  f_state_t           f_state_reg;
  x_state_t           x_state_reg;
  logic               hold_valid_reg;
  logic [1:0]         hold_if_type_reg;
  logic [1:0]         hold_idex_type_reg;
  logic [DELTA_W-1:0] hold_delta_reg;
  logic [31:0]        hold_if_pc_reg;
  logic [31:0]        hold_if_insn_reg;
  logic               hold_if_c_reg;
  logic [15:0]        hold_if_c_insn_reg;
  logic [31:0]        hold_idex_pc_reg;
  logic [DELTA_W-1:0] gap_reg;
  logic               apply;
  logic               f_err;
  logic               x_err;

  // Everything here depends only on registers, so ev_valid never reaches ev_ready.
  assign apply    = hold_valid_reg && (gap_reg >= hold_delta_reg);
  assign ev_ready = !hold_valid_reg || apply;
  assign busy     = hold_valid_reg || (f_state_reg == F_STALL) || (x_state_reg == X_MULT);

  assign f_err = apply &&
                 ((((hold_if_type_reg == EV_SINGLE) || (hold_if_type_reg == EV_START)) &&
                   (f_state_reg == F_STALL)) ||
                  ((hold_if_type_reg == EV_END) && (f_state_reg == F_IDLE)));
  assign x_err = apply &&
                 ((((hold_idex_type_reg == EV_SINGLE) || (hold_idex_type_reg == EV_START)) &&
                   (x_state_reg == X_MULT)) ||
                  ((hold_idex_type_reg == EV_END) && (x_state_reg == X_IDLE)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_reg     <= 1'b0;
      hold_if_type_reg   <= EV_NONE;
      hold_idex_type_reg <= EV_NONE;
      hold_delta_reg     <= '0;
      hold_if_pc_reg     <= '0;
      hold_if_insn_reg   <= '0;
      hold_if_c_reg      <= 1'b0;
      hold_if_c_insn_reg <= '0;
      hold_idex_pc_reg   <= '0;
      gap_reg            <= '0;
      proto_err          <= 1'b0;
      underrun           <= 1'b0;
    end else begin
      if (ev_valid && ev_ready) begin
        hold_valid_reg     <= 1'b1;
        hold_if_type_reg   <= ev_if_type;
        hold_idex_type_reg <= ev_idex_type;
        hold_delta_reg     <= ev_delta;
        hold_if_pc_reg     <= ev_if_pc;
        hold_if_insn_reg   <= ev_if_insn;
        hold_if_c_reg      <= ev_if_c;
        hold_if_c_insn_reg <= ev_if_c_insn;
        hold_idex_pc_reg   <= ev_idex_pc;
      end else if (apply) begin
        hold_valid_reg <= 1'b0;
      end
      // A gap already past delta can only be seen on the first hold cycle: the record came late.
      if (apply) begin
        gap_reg <= '0;
        if (gap_reg > hold_delta_reg) underrun <= 1'b1;
      end else if (gap_reg != '1) begin
        gap_reg <= gap_reg + DELTA_W'(1);
      end
      if (f_err || x_err) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_state_reg  <= F_IDLE;
      fetch_ready  <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_pc     <= '0;
      fetch_insn   <= '0;
      fetch_c      <= 1'b0;
      fetch_c_insn <= '0;
    end else begin
      fetch_ready <= (f_state_reg == F_STALL);
      fetch_valid <= 1'b0;
      if (apply) begin
        case (hold_if_type_reg)
          EV_SINGLE, EV_END: begin
            fetch_ready  <= 1'b1;
            fetch_valid  <= 1'b1;
            fetch_pc     <= hold_if_pc_reg;
            fetch_insn   <= hold_if_insn_reg;
            fetch_c      <= hold_if_c_reg;
            fetch_c_insn <= hold_if_c_insn_reg;
            f_state_reg  <= F_IDLE;
          end
          EV_START: begin
            fetch_ready <= 1'b1;
            f_state_reg <= F_STALL;
          end
          default: ;
        endcase
      end
    end
  end

  // The PC is refreshed on MULT_START too, since executing is already high on that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_state_reg    <= X_IDLE;
      idex_executing <= 1'b0;
      idex_done      <= 1'b0;
      idex_pc        <= '0;
    end else begin
      idex_executing <= (x_state_reg == X_MULT);
      idex_done      <= 1'b0;
      if (apply) begin
        case (hold_idex_type_reg)
          EV_SINGLE, EV_END: begin
            idex_executing <= 1'b1;
            idex_done      <= 1'b1;
            idex_pc        <= hold_idex_pc_reg;
            x_state_reg    <= X_IDLE;
          end
          EV_START: begin
            idex_executing <= 1'b1;
            idex_pc        <= hold_idex_pc_reg;
            x_state_reg    <= X_MULT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ibex_microarchtrace_replay.sv
// Bench for the trace replayer: a record-level schedule model predicts accept/apply edges
// and the resulting handshake waveform, compared every cycle against the DUT.
module tb_ibex_microarchtrace_replay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_if_type;
  logic [1:0]  ev_idex_type;
  logic [15:0] ev_delta;
  logic [31:0] ev_if_pc;
  logic [31:0] ev_if_insn;
  logic        ev_if_c;
  logic [15:0] ev_if_c_insn;
  logic [31:0] ev_idex_pc;
  logic        fetch_ready, fetch_valid, fetch_c;
  logic [31:0] fetch_pc, fetch_insn, idex_pc;
  logic [15:0] fetch_c_insn;
  logic        idex_executing, idex_done, busy, proto_err, underrun;

  ibex_microarchtrace_replay #(.DELTA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_if_type(ev_if_type), .ev_idex_type(ev_idex_type), .ev_delta(ev_delta),
    .ev_if_pc(ev_if_pc), .ev_if_insn(ev_if_insn), .ev_if_c(ev_if_c),
    .ev_if_c_insn(ev_if_c_insn), .ev_idex_pc(ev_idex_pc),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_insn(fetch_insn), .fetch_c(fetch_c), .fetch_c_insn(fetch_c_insn),
    .idex_executing(idex_executing), .idex_done(idex_done), .idex_pc(idex_pc),
    .busy(busy), .proto_err(proto_err), .underrun(underrun)
  );

  always #5 clk = ~clk;

  localparam logic [120:0] RST_VEC = {1'b1, 120'd0};

  int n_checks = 0;
  int n_fail   = 0;

  // Record list for the current scenario plus the model's schedule and expected waveform.
  int          n_rec;
  int          r_idle[64];
  int          r_delta[64];
  logic [1:0]  r_ift[64];
  logic [1:0]  r_xt[64];
  logic [31:0] r_pc[64];
  logic [31:0] r_insn[64];
  logic        r_c[64];
  logic [15:0] r_ci[64];
  logic [31:0] r_ipc[64];
  int          pres[64];
  int          acc[64];
  int          app[64];
  logic        und[64];
  int          n_edges;
  logic [120:0] exp_vec[0:1023];

  function automatic logic [120:0] obs();
    return {ev_ready, fetch_ready, fetch_valid, fetch_pc, fetch_insn, fetch_c, fetch_c_insn,
            idex_executing, idex_done, idex_pc, busy, proto_err, underrun};
  endfunction

  task automatic add_rec(input int idle, input logic [1:0] ift, input logic [1:0] xt,
                         input int delta, input logic [31:0] pc, input logic [31:0] ipc);
    r_idle[n_rec]  = idle;
    r_ift[n_rec]   = ift;
    r_xt[n_rec]    = xt;
    r_delta[n_rec] = delta;
    r_pc[n_rec]    = pc;
    r_insn[n_rec]  = $urandom;
    r_c[n_rec]     = 1'($urandom_range(0, 1));
    r_ci[n_rec]    = 16'($urandom);
    r_ipc[n_rec]   = ipc;
    n_rec++;
  endtask

  // Edge 0 is the reset edge and counts as the reference point for the first delta.
  // A record is accepted once presented and the previous one has applied; it applies
  // delta+1 edges after the previous apply, or one edge after acceptance if that is later.
  task automatic build_model();
    int p, prev_acc, k;
    logic fs, xm, fr, fv, c, ex, dn, perr, undf, holdv, rdy;
    logic [31:0] pc, insn, ipc;
    logic [15:0] ci;
    p = 0; prev_acc = 0;
    for (int n = 0; n < n_rec; n++) begin
      pres[n] = prev_acc + 1 + r_idle[n];
      acc[n]  = (n > 0 && app[n-1] > pres[n]) ? app[n-1] : pres[n];
      und[n]  = (acc[n] - p) > r_delta[n];
      app[n]  = (acc[n] + 1 > p + r_delta[n] + 1) ? acc[n] + 1 : p + r_delta[n] + 1;
      p = app[n];
      prev_acc = acc[n];
    end
    n_edges = app[n_rec-1] + 3;
    fs = 0; xm = 0; fr = 0; fv = 0; c = 0; ex = 0; dn = 0; perr = 0; undf = 0;
    pc = 0; insn = 0; ipc = 0; ci = 0; k = 0;
    for (int e = 0; e <= n_edges; e++) begin
      fr = fs; fv = 0; ex = xm; dn = 0;
      if (e > 0 && k < n_rec && app[k] == e) begin
        case (r_ift[k])
          2'd1: begin fr = 1; fv = 1; pc = r_pc[k]; insn = r_insn[k]; c = r_c[k]; ci = r_ci[k];
                      if (fs) perr = 1; fs = 0; end
          2'd2: begin fr = 1; if (fs) perr = 1; fs = 1; end
          2'd3: begin fr = 1; fv = 1; pc = r_pc[k]; insn = r_insn[k]; c = r_c[k]; ci = r_ci[k];
                      if (!fs) perr = 1; fs = 0; end
          default: ;
        endcase
        case (r_xt[k])
          2'd1: begin ex = 1; dn = 1; ipc = r_ipc[k]; if (xm) perr = 1; xm = 0; end
          2'd2: begin ex = 1; ipc = r_ipc[k]; if (xm) perr = 1; xm = 1; end
          2'd3: begin ex = 1; dn = 1; ipc = r_ipc[k]; if (!xm) perr = 1; xm = 0; end
          default: ;
        endcase
        if (und[k]) undf = 1;
        k++;
      end
      holdv = (k < n_rec) && (acc[k] <= e);
      rdy   = !(holdv && app[k] != e + 1);
      exp_vec[e] = {rdy, fr, fv, pc, insn, c, ci, ex, dn, ipc, holdv || fs || xm, perr, undf};
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ev_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives the inputs seen by edge e, then advances to the sampling point after it.
  task automatic step(input int e);
    int sel;
    sel = -1;
    for (int n = 0; n < n_rec; n++)
      if (pres[n] <= e && e <= acc[n]) sel = n;
    ev_valid     = (sel >= 0);
    ev_if_type   = (sel >= 0) ? r_ift[sel]   : 2'($urandom);
    ev_idex_type = (sel >= 0) ? r_xt[sel]    : 2'($urandom);
    ev_delta     = (sel >= 0) ? 16'(r_delta[sel]) : 16'($urandom);
    ev_if_pc     = (sel >= 0) ? r_pc[sel]    : $urandom;
    ev_if_insn   = (sel >= 0) ? r_insn[sel]  : $urandom;
    ev_if_c      = (sel >= 0) ? r_c[sel]     : 1'($urandom);
    ev_if_c_insn = (sel >= 0) ? r_ci[sel]    : 16'($urandom);
    ev_idex_pc   = (sel >= 0) ? r_ipc[sel]   : $urandom;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ev_valid = 1'b1; ev_if_type = 2'd2; ev_idex_type = 2'd2; ev_delta = 16'd0;
    end
    apply_reset();
    n_checks++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset got=%h want=%h", obs(), RST_VEC);
    end
  endtask

  task automatic test_single_if();
    n_rec = 0;
    add_rec(0, 2'd1, 2'd0, 0, 32'h80, 32'h0);
    r_insn[0] = 32'h0000_0013;
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL single_if edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
  endtask

  task automatic test_if_multicycle();
    n_rec = 0;
    add_rec(1, 2'd2, 2'd0, 2, 32'h0, 32'h0);
    add_rec(0, 2'd3, 2'd0, 3, 32'h84, 32'h0);
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL if_multicycle edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
  endtask

  task automatic test_mult();
    n_rec = 0;
    add_rec(0, 2'd0, 2'd1, 0, 32'h0, 32'h100);
    add_rec(0, 2'd0, 2'd2, 0, 32'h0, 32'h104);
    add_rec(0, 2'd0, 2'd3, 0, 32'h0, 32'h104);
    add_rec(0, 2'd1, 2'd1, 2, 32'h200, 32'h1FC);
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL mult_combined edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
  endtask

  task automatic test_proto_err();
    n_rec = 0;
    add_rec(0, 2'd3, 2'd0, 1, 32'h40, 32'h0);
    add_rec(0, 2'd2, 2'd0, 1, 32'h0, 32'h0);
    add_rec(2, 2'd2, 2'd3, 0, 32'h0, 32'h88);
    add_rec(0, 2'd3, 2'd0, 3, 32'h44, 32'h0);
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL proto_err edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
  endtask

  task automatic test_back_to_back();
    n_rec = 0;
    for (int i = 0; i < 6; i++) add_rec(0, 2'd1, 2'd1, 0, 32'h300 + 4 * i, 32'h2FC + 4 * i);
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL back_to_back edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
  endtask

  task automatic test_underrun_reset();
    n_rec = 0;
    add_rec(10, 2'd1, 2'd0, 4, 32'h500, 32'h0);
    add_rec(0, 2'd3, 2'd0, 1, 32'h504, 32'h0);
    add_rec(0, 2'd0, 2'd2, 0, 32'h0, 32'h508);
    build_model();
    apply_reset();
    for (int e = 0; e <= n_edges; e++) begin
      if (e > 0) step(e);
      n_checks++;
      if (obs() !== exp_vec[e]) begin
        n_fail++;
        $display("FAIL underrun edge=%0d got=%h want=%h", e, obs(), exp_vec[e]);
      end
    end
    rst_n = 1'b0;
    ev_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_mult got=%h want=%h", obs(), RST_VEC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      n_rec = 0;
      for (int i = 0; i < 40; i++)
        add_rec(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                2'($urandom), 2'($urandom), int'($urandom_range(0, 3)), $urandom, $urandom);
      build_model();
      apply_reset();
      for (int e = 0; e <= n_edges; e++) begin
        if (e > 0) step(e);
        n_checks++;
        if (obs() !== exp_vec[e]) begin
          n_fail++;
          $display("FAIL random round=%0d edge=%0d got=%h want=%h", round, e, obs(), exp_vec[e]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ev_valid = 1'b0; ev_if_type = 2'd0; ev_idex_type = 2'd0; ev_delta = 16'd0;
    ev_if_pc = 32'd0; ev_if_insn = 32'd0; ev_if_c = 1'b0; ev_if_c_insn = 16'd0; ev_idex_pc = 32'd0;
    test_reset();
    test_single_if();
    test_if_multicycle();
    test_mult();
    test_proto_err();
    test_back_to_back();
    test_underrun_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_microarchtrace_replay.md
# ibex_microarchtrace_replay

Synthesizable trace replayer: consumes a stream of per-cycle pipeline-event records and regenerates the Ibex fetch and ID/EX handshake signals cycle-accurately. It is the decoding end of the microarchitecture trace. It drives the same signal set the trace monitor observes: fetch_ready/valid/pc/insn/c/c_insn and idex_executing/done/pc. Feeding its outputs into the monitor must reproduce the original event sequence. Used to re-run captured traces in simulation and in FPGA trace-visualisation setups without a live core.

## Interface
- DELTA_W, 16, width of the inter-record idle-cycle count
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- ev_valid  input  1  record available
- ev_ready  output  1  record accepted when ev_valid && ev_ready at a rising edge
- ev_if_type  input  2  0 none, 1 IF (single-cycle fetch), 2 IF_START, 3 IF_END
- ev_idex_type  input  2  0 none, 1 IDEX (single-cycle), 2 MULT_START, 3 MULT_END
- ev_delta  input  DELTA_W  idle cycles between the previous record's apply cycle and this record's apply cycle
- ev_if_pc, ev_if_insn  input  32 each  fetch PC and instruction
- ev_if_c  input  1  compressed flag
- ev_if_c_insn  input  16  compressed instruction
- ev_idex_pc  input  32  ID/EX PC
- fetch_ready, fetch_valid  output  1 each  regenerated fetch handshake
- fetch_pc, fetch_insn  output  32 each;  fetch_c  output  1;  fetch_c_insn  output  16
- idex_executing, idex_done  output  1 each;  idex_pc  output  32
- busy  output  1  hold register valid, or either stage in a multicycle state
- proto_err  output  1  sticky: illegal event ordering seen
- underrun  output  1  sticky: record arrived after its scheduled apply cycle

## Operation
- One-entry hold register.
  - ev_ready = !hold_valid || apply.
  - An accepted record loads the hold register at the edge.
- Gap counter, DELTA_W bits:
  - Cleared on every apply edge.
  - Incremented on every other edge; saturates at all-ones.
- apply = hold_valid && (gap >= hold.delta).
  - If gap > delta at first hold cycle, apply immediately and set underrun.
- Fetch FSM, states F_IDLE and F_STALL. On each edge:
  - No apply, or if_type none: F_STALL gives ready=1, valid=0; F_IDLE gives ready=0, valid=0.
  - IF: ready=1, valid=1, load pc/insn/c/c_insn. Next state F_IDLE. If the state was F_STALL, set proto_err.
  - IF_START: ready=1, valid=0. Next state F_STALL. If already F_STALL, set proto_err.
  - IF_END: ready=1, valid=1, load fields. Next state F_IDLE. If the state was F_IDLE, set proto_err; drive as IF.
- ID/EX FSM, states X_IDLE and X_MULT. Same rules with executing/done and idex_pc:
  - MULT_START gives executing=1, done=0.
  - MULT_END gives executing=1, done=1.
  - X_MULT holds executing=1, done=0 on non-apply cycles.
- fetch and idex fields on outputs retain their last loaded value when not refreshed.
- Both channels of one record apply on the same edge. Records are strictly in order.
- busy = hold_valid || F_STALL || X_MULT.

## Timing
- Reset, synchronous:
  - All outputs 0 except ev_ready=1.
  - hold_valid=0, gap=0, FSMs idle, sticky flags cleared.
  - Reset mid-multicycle abandons the operation; outputs are 0 on the edge after rst_n sampled low.
- All handshake outputs are registered.
  - Record accepted at edge k with gap already >= delta is visible on outputs after edge k+1.
  - After edge k+1, gap counting restarts.
- delta=0: applies on the edge immediately following the previous apply, i.e. back-to-back cycles. Sustained 1 record/cycle when ev_valid is continuously high.
- A single-cycle event (IF, IDEX, *_END) drives its outputs for exactly one cycle. The next cycle reverts per FSM state unless another record applies.
- Consecutive IF records with delta=0 hold ready=valid=1 for consecutive cycles with new pc each cycle.
- ev_ready low only when hold is full and not applying this cycle. No combinational path from ev_valid to ev_ready.

## Test plan
- Reset, then a single record {IF, pc=0x80, insn=0x00000013, delta=0} → one cycle of ready=valid=1, fetch_pc=0x80, then ready=valid=0. busy=0 afterwards.
- Records IF_START delta=2, then IF_END pc=0x84 delta=3 → 3 idle cycles, ready=1/valid=0 for 4 cycles, then one cycle ready=valid=1 pc=0x84. proto_err=0.
- Records IDEX pc=0x100, MULT_START pc=0x104, MULT_END pc=0x104, all delta=0 → executing=1 for 3 cycles; done=1,0,1. Chained through the monitor, this yields idex, mult_start, mult_end.
- Combined record {IF pc=0x200, IDEX pc=0x1FC} → both channels asserted on the same cycle.
- IF_END while F_IDLE → outputs as IF, proto_err=1 and stays 1 until reset. A second IF_START while F_STALL → proto_err=1.
- ev_valid held low for 10 cycles, then a record with delta=4 → applied on the edge after acceptance, underrun=1. Asserting rst_n=0 during X_MULT → executing=0 next cycle, underrun and proto_err cleared.
